// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Every access is a fixed IDLE -> ISSUE -> RESP sequence.
module dmem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [7:0]  addr0,
  input  logic [7:0]  wdata0,
  output logic        ack0,
  output logic [7:0]  rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [7:0]  addr1,
  input  logic [7:0]  wdata1,
  output logic        ack1,
  output logic [7:0]  rdata1,
  output logic        mem_en,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic [15:0] stall0_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        win_q, win_d;
  logic        we_q, we_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rd0_q, rd0_d;
  logic [7:0]  rd1_q, rd1_d;
  logic [15:0] stall_q, stall_d;
  logic        grant;
  logic        start;
  logic [7:0]  resp_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rd0_q   <= 8'h00;
      rd1_q   <= 8'h00;
      stall_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req0 || req1) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // On contention the port that did not win last time gets the bus.
  assign grant     = (req0 && req1) ? ~last_q : req1;
  assign start     = (state_q == IDLE) && (req0 || req1);
  assign resp_data = we_q ? 8'h00 : mem_rdata;

  always_comb begin
    last_d  = last_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    stall_d = stall_q;
    if (start) begin
      last_d  = grant;
      win_d   = grant;
      we_d    = grant ? we1 : we0;
      addr_d  = grant ? addr1 : addr0;
      wdata_d = grant ? wdata1 : wdata0;
    end
    if (ack0) rd0_d = resp_data;
    if (ack1) rd1_d = resp_data;
    if (req0 && !ack0 && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_comb begin
    mem_en     = (state_q == ISSUE);
    mem_we     = mem_en && we_q;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    ack0       = (state_q == RESP) && !win_q;
    ack1       = (state_q == RESP) && win_q;
    rdata0     = ack0 ? resp_data : rd0_q;
    rdata1     = ack1 ? resp_data : rd1_q;
    busy       = (state_q != IDLE);
    stall0_cnt = stall_q;
  end

endmodule
